// File: rtl/mp64_trng_health.sv
// mp64_trng_health: online health tests for a raw TRNG bit stream.
// A repetition-count test (RCT) and an adaptive-proportion test (APT) watch
// every accepted sample. After one clean APT window the block enters RUN and
// packs samples MSB-first into 64-bit words for the entropy pool.
module mp64_trng_health #(
  parameter int RCT_CUTOFF = 21,
  parameter int APT_WINDOW = 1024,
  parameter int APT_CUTOFF = 589
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        raw_bit,
  input  logic        raw_valid,
  input  logic        clear_alarm,
  output logic [63:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        healthy,
  output logic        alarm,
  output logic [1:0]  alarm_cause,
  output logic        overrun
);

  localparam int RW = $clog2(RCT_CUTOFF + 1);
  localparam int MW = $clog2(APT_CUTOFF + 1);
  localparam int WW = (APT_WINDOW > 1) ? $clog2(APT_WINDOW) : 1;

  typedef enum logic [1:0] {STARTUP, RUN, ALARM} state_t;

  state_t        state;
  logic [RW-1:0] rep_count;
  logic          last_bit;
  logic [WW-1:0] win_count;
  logic [MW-1:0] match_count;
  logic          ref_bit;
  logic [63:0]   shift;
  logic [5:0]    bit_count;

  logic          accept;
  logic          rct_hit;
  logic          apt_hit;
  logic          win_last;
  logic [RW-1:0] rep_next;
  logic [MW-1:0] match_next;
  logic [63:0]   word_next;

  // Health-test next values for the sample offered this cycle.
  always_comb begin
    accept     = raw_valid && (state != ALARM) && !clear_alarm;
    // rep_count of zero means no sample seen since reset/clear
    rep_next   = ((rep_count != '0) && (raw_bit == last_bit)) ? rep_count + RW'(1) : RW'(1);
    // win_count of zero means this sample opens a window and becomes the reference
    if (win_count == '0)
      match_next = MW'(1);
    else if (raw_bit == ref_bit)
      match_next = match_count + MW'(1);
    else
      match_next = match_count;
    win_last   = (win_count == WW'(APT_WINDOW - 1));
    rct_hit    = accept && (rep_next == RW'(RCT_CUTOFF));
    apt_hit    = accept && (match_next == MW'(APT_CUTOFF));
    word_next  = {shift[62:0], raw_bit};
  end

  // FSM, health counters, word assembly and output handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= STARTUP;
      rep_count   <= '0;
      last_bit    <= 1'b0;
      win_count   <= '0;
      match_count <= '0;
      ref_bit     <= 1'b0;
      shift       <= '0;
      bit_count   <= '0;
      out_data    <= '0;
      out_valid   <= 1'b0;
      healthy     <= 1'b0;
      alarm       <= 1'b0;
      alarm_cause <= '0;
      overrun     <= 1'b0;
    end else begin
      overrun <= 1'b0;
      // a completed handshake drops out_valid unless a new word loads below
      if (out_valid && out_ready)
        out_valid <= 1'b0;

      if (state == ALARM) begin
        if (clear_alarm) begin
          state       <= STARTUP;
          alarm       <= 1'b0;
          alarm_cause <= '0;
          rep_count   <= '0;
          win_count   <= '0;
          match_count <= '0;
          shift       <= '0;
          bit_count   <= '0;
        end
      end else if (rct_hit || apt_hit) begin
        state       <= ALARM;
        alarm       <= 1'b1;
        healthy     <= 1'b0;
        alarm_cause <= {apt_hit, rct_hit};
        out_valid   <= 1'b0;
        shift       <= '0;
        bit_count   <= '0;
      end else if (accept) begin
        rep_count   <= rep_next;
        last_bit    <= raw_bit;
        match_count <= match_next;
        if (win_count == '0)
          ref_bit <= raw_bit;
        win_count <= win_last ? '0 : win_count + WW'(1);

        if (state == STARTUP) begin
          if (win_last) begin
            state     <= RUN;
            healthy   <= 1'b1;
            shift     <= '0;
            bit_count <= '0;
          end
        end else begin
          shift     <= word_next;
          bit_count <= bit_count + 6'd1;
          if (bit_count == 6'd63) begin
            if (!out_valid || out_ready) begin
              out_data  <= word_next;
              out_valid <= 1'b1;
            end else begin
              overrun <= 1'b1;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_mp64_trng_health.sv
// Testbench for mp64_trng_health: table of 64-bit words streamed in RUN with a
// scoreboard of expected pool words, plus hand-written health-test sequences.
module tb_mp64_trng_health;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        raw_bit;
  logic        raw_valid;
  logic        clear_alarm;
  logic        out_ready;
  logic [63:0] out_data;
  logic        out_valid;
  logic        healthy;
  logic        alarm;
  logic [1:0]  alarm_cause;
  logic        overrun;

  logic        raw_bit2;
  logic        raw_valid2;
  logic        clear_alarm2;
  logic        out_ready2;
  logic [63:0] out_data2;
  logic        out_valid2;
  logic        healthy2;
  logic        alarm2;
  logic [1:0]  alarm_cause2;
  logic        overrun2;

  int          checks = 0;
  int          failures = 0;
  logic [63:0] exp_q[$];
  logic [63:0] sb_exp;

  typedef struct {
    logic [63:0] word;
    logic        ready;
    logic        push;
    logic        drain;
    logic        exp_valid;
    logic [63:0] exp_data;
    logic        exp_overrun;
  } vec_t;

  vec_t vec[7];

  always #5 clk = ~clk;

  mp64_trng_health dut (
    .clk(clk), .rst_n(rst_n), .raw_bit(raw_bit), .raw_valid(raw_valid),
    .clear_alarm(clear_alarm), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .healthy(healthy), .alarm(alarm),
    .alarm_cause(alarm_cause), .overrun(overrun)
  );

  mp64_trng_health #(.RCT_CUTOFF(4), .APT_WINDOW(8), .APT_CUTOFF(4)) dut_small (
    .clk(clk), .rst_n(rst_n), .raw_bit(raw_bit2), .raw_valid(raw_valid2),
    .clear_alarm(clear_alarm2), .out_data(out_data2), .out_valid(out_valid2),
    .out_ready(out_ready2), .healthy(healthy2), .alarm(alarm2),
    .alarm_cause(alarm_cause2), .overrun(overrun2)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    raw_bit   = b;
    raw_valid = 1'b1;
    step();
    raw_valid = 1'b0;
  endtask

  // Scoreboard: each accepted pool word must match the next expected word.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected actual=%h expected=<none>", out_data);
      end else begin
        sb_exp = exp_q.pop_front();
        check("sb_word", out_data, sb_exp);
      end
    end
  end

  initial begin
    int          bad;
    logic [63:0] w;

    rst_n = 1'b0; raw_bit = 1'b0; raw_valid = 1'b0; clear_alarm = 1'b0; out_ready = 1'b0;
    raw_bit2 = 1'b0; raw_valid2 = 1'b0; clear_alarm2 = 1'b0; out_ready2 = 1'b0;

    vec[0] = '{64'h0123456789ABCDEF, 1'b1, 1'b1, 1'b0, 1'b1, 64'h0123456789ABCDEF, 1'b0};
    vec[1] = '{64'hFEDCBA9876543210, 1'b1, 1'b1, 1'b0, 1'b1, 64'hFEDCBA9876543210, 1'b0};
    vec[2] = '{64'hA5A5A5A5A5A5A5A5, 1'b1, 1'b1, 1'b0, 1'b1, 64'hA5A5A5A5A5A5A5A5, 1'b0};
    vec[3] = '{64'h00FF00FF00FF00FF, 1'b1, 1'b1, 1'b0, 1'b1, 64'h00FF00FF00FF00FF, 1'b0};
    vec[4] = '{64'h3C3C3C3C3C3C3C3C, 1'b0, 1'b1, 1'b0, 1'b1, 64'h3C3C3C3C3C3C3C3C, 1'b0};
    vec[5] = '{64'h5A5A5A5A5A5A5A5A, 1'b0, 1'b0, 1'b1, 1'b1, 64'h3C3C3C3C3C3C3C3C, 1'b1};
    vec[6] = '{64'h3C3C3C3C3C3C3C3C, 1'b0, 1'b0, 1'b0, 1'b1, 64'h3C3C3C3C3C3C3C3C, 1'b0};

    repeat (3) step();
    check("rst_out_data", out_data, 64'h0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_healthy", healthy, 1'b0);
    check("rst_alarm", alarm, 1'b0);
    check("rst_alarm_cause", alarm_cause, 2'b00);
    check("rst_overrun", overrun, 1'b0);
    rst_n = 1'b1;
    step();

    // Small instance: both tests trip on the same (4th) sample.
    for (int i = 0; i < 4; i++) begin
      raw_bit2 = 1'b1; raw_valid2 = 1'b1;
      step();
      raw_valid2 = 1'b0;
      if (i == 2) check("small_no_alarm_3", alarm2, 1'b0);
    end
    check("small_alarm", alarm2, 1'b1);
    check("small_cause_both", alarm_cause2, 2'b11);

    // Startup window of alternating samples.
    bad = 0;
    for (int i = 0; i < 1024; i++) begin
      if (healthy !== 1'b0 || out_valid !== 1'b0) bad++;
      send_bit(i[0]);
    end
    check("startup_low", bad, 0);
    check("startup_healthy", healthy, 1'b1);
    check("startup_valid", out_valid, 1'b0);

    // Table of words in RUN.
    for (int v = 0; v < 7; v++) begin
      out_ready = vec[v].ready;
      if (vec[v].push) exp_q.push_back(vec[v].word);
      w = vec[v].word;
      bad = 0;
      for (int b = 63; b >= 0; b--) begin
        send_bit(w[b]);
        if (b != 0 && overrun !== 1'b0) bad++;
      end
      check($sformatf("vec%0d_no_early_overrun", v), bad, 0);
      check($sformatf("vec%0d_valid", v), out_valid, vec[v].exp_valid);
      check($sformatf("vec%0d_data", v), out_data, vec[v].exp_data);
      check($sformatf("vec%0d_overrun", v), overrun, vec[v].exp_overrun);
      if (vec[v].ready || vec[v].drain) begin
        out_ready = 1'b1;
        step();
        check($sformatf("vec%0d_valid_clear", v), out_valid, 1'b0);
        check($sformatf("vec%0d_overrun_pulse", v), overrun, 1'b0);
        out_ready = vec[v].ready;
      end
    end

    // RCT: 21 ones with a pending word held (out_ready=0).
    for (int i = 0; i < 21; i++) begin
      send_bit(1'b1);
      if (i == 19) begin
        check("rct_no_alarm_20", alarm, 1'b0);
        check("rct_pending_valid", out_valid, 1'b1);
      end
    end
    check("rct_alarm", alarm, 1'b1);
    check("rct_cause", alarm_cause, 2'b01);
    check("rct_healthy", healthy, 1'b0);
    check("rct_valid", out_valid, 1'b0);

    // ALARM holds while samples keep arriving.
    for (int i = 0; i < 5; i++) send_bit(i[0]);
    check("hold_alarm", alarm, 1'b1);
    check("hold_cause", alarm_cause, 2'b01);
    check("hold_healthy", healthy, 1'b0);

    // Clear together with a valid sample: sample must not count.
    raw_bit = 1'b1; raw_valid = 1'b1; clear_alarm = 1'b1;
    step();
    raw_valid = 1'b0; clear_alarm = 1'b0;
    check("clear_alarm", alarm, 1'b0);
    check("clear_cause", alarm_cause, 2'b00);
    check("clear_healthy", healthy, 1'b0);
    bad = 0;
    for (int i = 0; i < 1023; i++) begin
      send_bit(i[0]);
      if (healthy !== 1'b0 || alarm !== 1'b0) bad++;
    end
    check("clear_restart_low", bad, 0);
    send_bit(1'b1);
    check("clear_restart_healthy", healthy, 1'b1);

    // Asynchronous reset mid-run.
    rst_n = 1'b0;
    #1;
    check("arst_healthy", healthy, 1'b0);
    check("arst_out_data", out_data, 64'h0);
    check("arst_out_valid", out_valid, 1'b0);
    check("arst_alarm", alarm, 1'b0);
    step();
    rst_n = 1'b1;
    step();

    // APT: repeating 1,1,1,0 trips on the 785th sample.
    bad = 0;
    for (int i = 0; i < 785; i++) begin
      if (alarm !== 1'b0 || healthy !== 1'b0) bad++;
      send_bit((i % 4) != 3);
    end
    check("apt_pre_clean", bad, 0);
    check("apt_alarm", alarm, 1'b1);
    check("apt_cause", alarm_cause, 2'b10);
    check("apt_healthy", healthy, 1'b0);

    step();
    check("sb_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
